inv_shift_row: RTL and testbench

INV_SHIFT_ROW -- requirements
Module: inv_shift_row

---
 rtl/inv_shift_row_pkg.sv | 29 ++
 rtl/isr_permute.sv | 27 ++
 rtl/inv_shift_row.sv | 92 +++++++++
 tb/tb_inv_shift_row.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_shift_row_pkg.sv
// AES state geometry shared by the inverse ShiftRows block: column/byte widths,
// the 128-bit state type and helpers that locate a (row, column) byte.
package inv_shift_row_pkg;

  localparam int NB     = 4;
  localparam int BW     = 8;
  localparam int COLW   = NB * BW;
  localparam int STATEW = NB * COLW;

  // Column 0 occupies the top word; row 0 is the top byte of each column.
  typedef logic [STATEW-1:0] state_t;

  function automatic int col_lsb(input int c);
    return STATEW - COLW * (c + 1);
  endfunction

  function automatic int byte_lsb(input int r, input int c);
    return col_lsb(c) + COLW - BW * (r + 1);
  endfunction

  function automatic int isr_src_col(input int r, input int c);
    return (c - r + NB) % NB;
  endfunction

  function automatic int fwd_src_col(input int r, input int c);
    return (c + r) % NB;
  endfunction

endpackage

// File: rtl/isr_permute.sv
// Combinational ShiftRows byte permutation: inverse by default, forward when
// fwd = 1 (fwd port only with INV_SHIFT_ROW_FWD_EN). Zero latency, no flow control.
module isr_permute
  import inv_shift_row_pkg::*;
(
`ifdef INV_SHIFT_ROW_FWD_EN
  input  logic   fwd,
`endif
  input  state_t din,
  output state_t dout
);

  always_comb begin
    dout = '0;
    for (int r = 0; r < NB; r++) begin
      for (int c = 0; c < NB; c++) begin
`ifdef INV_SHIFT_ROW_FWD_EN
        dout[byte_lsb(r, c) +: BW] = fwd ? din[byte_lsb(r, fwd_src_col(r, c)) +: BW]
                                         : din[byte_lsb(r, isr_src_col(r, c)) +: BW];
`else
        dout[byte_lsb(r, c) +: BW] = din[byte_lsb(r, isr_src_col(r, c)) +: BW];
`endif
      end
    end
  end

endmodule

// File: rtl/inv_shift_row.sv
// Inverse ShiftRows into a DEPTH-entry FIFO; output visible the edge a block lands in
// an empty FIFO; in_ready drops when full unless a pop frees a slot. INV_SHIFT_ROW_FWD_EN adds dir.
module inv_shift_row
  import inv_shift_row_pkg::*;
#(
  parameter int DEPTH = 2
) (
`ifdef INV_SHIFT_ROW_FWD_EN
  input  logic        dir,
`endif
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] SR1,
  input  logic [31:0] SR2,
  input  logic [31:0] SR3,
  input  logic [31:0] SR4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ISR1,
  output logic [31:0] ISR2,
  output logic [31:0] ISR3,
  output logic [31:0] ISR4,
  output logic [3:0]  level
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  state_t          mem [DEPTH];
  state_t          din;
  state_t          perm;
  state_t          dout;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            rdy_en;
  logic            push;
  logic            pop;

  assign din = {SR1, SR2, SR3, SR4};

  isr_permute u_permute (
`ifdef INV_SHIFT_ROW_FWD_EN
    .fwd  (dir),
`endif
    .din  (din),
    .dout (perm)
  );

  assign out_valid = (level != 4'd0);
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign in_ready  = rdy_en & ~flush & ((level < DEPTH_L) | out_ready);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= perm;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_en <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   level <= level + 4'd1;
          2'b01:   level <= level - 4'd1;
          default: level <= level;
        endcase
      end
    end
  end

  // Empty entries read as zero so reset and flush present a clean all-zero output.
  assign dout = out_valid ? mem[rd_ptr] : '0;
  assign {ISR1, ISR2, ISR3, ISR4} = dout;

endmodule

// File: tb/tb_inv_shift_row.sv
// Scoreboard bench for inv_shift_row: reference ShiftRows model on byte matrices,
// queue-based FIFO model, monitor compares every cycle on the falling edge.
module tb_inv_shift_row;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] SR1 = '0, SR2 = '0, SR3 = '0, SR4 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ISR1, ISR2, ISR3, ISR4;
  logic [3:0]  level;
  logic        dir_tb = 1'b0;

  logic [127:0] cur_exp = '0;
  logic [127:0] q[$];
  bit           m_rdy = 1'b0;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  inv_shift_row #(.DEPTH(DEPTH)) dut (
`ifdef INV_SHIFT_ROW_FWD_EN
    .dir       (dir_tb),
`endif
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SR1       (SR1),
    .SR2       (SR2),
    .SR3       (SR3),
    .SR4       (SR4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ISR1      (ISR1),
    .ISR2      (ISR2),
    .ISR3      (ISR3),
    .ISR4      (ISR4),
    .level     (level)
  );

  // Reference: build a 4x4 byte matrix, then out[r][c] = in[r][(c -/+ r) mod 4].
  function automatic logic [127:0] ref_shift(input logic [31:0] a, b, c, d, input logic fwd);
    logic [31:0]  cols [4];
    logic [7:0]   m [4][4];
    logic [127:0] res;
    int           sc;
    cols[0] = a; cols[1] = b; cols[2] = c; cols[3] = d;
    for (int col = 0; col < 4; col++)
      for (int r = 0; r < 4; r++)
        m[r][col] = cols[col][31-8*r -: 8];
    res = '0;
    for (int col = 0; col < 4; col++)
      for (int r = 0; r < 4; r++) begin
        sc = fwd ? (col + r) % 4 : (col + 4 - r) % 4;
        res[127-32*col-8*r -: 8] = m[r][sc];
      end
    return res;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) m_rdy = 1'b0;
    else        m_rdy = 1'b1;
  end

  // Monitor: check outputs against the queue model, then advance the model.
  always @(negedge clk) begin
    bit exp_rdy;
    bit do_pop;
    bit do_push;
    if (!reset) begin
      chk("rst_level", 128'(level), 128'd0);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_in_ready", 128'(in_ready), 128'd0);
      chk("rst_isr", {ISR1, ISR2, ISR3, ISR4}, 128'd0);
      q.delete();
    end else begin
      exp_rdy = m_rdy && !flush && ((q.size() < DEPTH) || out_ready);
      chk("level", 128'(level), 128'(q.size()));
      chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
      chk("in_ready", 128'(in_ready), 128'(exp_rdy));
      if (q.size() != 0) chk("isr_data", {ISR1, ISR2, ISR3, ISR4}, q[0]);
      if (flush) begin
        q.delete();
      end else begin
        do_pop  = (q.size() != 0) && out_ready;
        do_push = in_valid && exp_rdy;
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(cur_exp);
      end
    end
  end

  task automatic set_blk(input logic [31:0] a, b, c, d, input logic [127:0] exp);
    SR1 = a; SR2 = b; SR3 = c; SR4 = d;
    cur_exp = exp;
  endtask

  task automatic push_blk(input logic [31:0] a, b, c, d, input logic [127:0] exp);
    bit acc;
    @(posedge clk); #1;
    set_blk(a, b, c, d, exp);
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
    end
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL push_timeout: in_ready stuck at 0, required 1");
    end
  endtask

  task automatic push_rand();
    logic [31:0] a, b, c, d;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    push_blk(a, b, c, d, ref_shift(a, b, c, d, dir_tb));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    idle();
    out_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = (level == 4'd0);
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_timeout: level %0d, required 0", level);
    end
  endtask

  initial begin
    logic [31:0] a, b, c, d;
    #22 reset = 1'b1;

    // Known-answer inverse vector.
    out_ready = 1'b1;
    push_blk(32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
             128'h000d0a07_04010e0b_0805020f_0c090603);
    drain();

    // Backpressure: two accepted, third waits until out_ready rises.
    out_ready = 1'b0;
    push_rand();
    push_rand();
    fork
      push_rand();
      begin repeat (4) @(posedge clk); #2 out_ready = 1'b1; end
    join
    drain();

    // Full FIFO with simultaneous push/pop over 8 back-to-back blocks.
    out_ready = 1'b0;
    push_rand();
    push_rand();
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (8) push_rand();
    drain();

    // Reset mid-stream.
    out_ready = 1'b0;
    push_rand();
    push_rand();
    idle();
    @(posedge clk); #1 reset = 1'b0;
    #1;
    chk("rst_now_level", 128'(level), 128'd0);
    chk("rst_now_out_valid", 128'(out_valid), 128'd0);
    chk("rst_now_isr", {ISR1, ISR2, ISR3, ISR4}, 128'd0);
    @(negedge clk); #1 reset = 1'b1;
    out_ready = 1'b1;
    push_rand();
    drain();

    // Flush with a concurrent block.
    out_ready = 1'b0;
    push_rand();
    push_rand();
    @(posedge clk); #1;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    set_blk(a, b, c, d, ref_shift(a, b, c, d, dir_tb));
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_level", 128'(level), 128'd0);
    out_ready = 1'b1;
    push_rand();
    drain();

`ifdef INV_SHIFT_ROW_FWD_EN
    dir_tb = 1'b1;
    push_blk(32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
             128'h00050a0f_04090e03_080d0207_0c01060b);
    dir_tb = 1'b0;
    push_blk(32'h00050a0f, 32'h04090e03, 32'h080d0207, 32'h0c01060b,
             128'h00010203_04050607_08090a0b_0c0d0e0f);
    drain();
`endif

    // Randomized traffic with occasional flush.
    repeat (400) begin
      @(posedge clk); #1;
      a = $urandom; b = $urandom; c = $urandom; d = $urandom;
`ifdef INV_SHIFT_ROW_FWD_EN
      dir_tb = 1'($urandom_range(0, 1));
`endif
      set_blk(a, b, c, d, ref_shift(a, b, c, d, dir_tb));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 31) == 0);
    end
    @(posedge clk); #1 flush = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
